// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: N-stage stall/flush/reset generator with a debug
// halt/drain/single-step state machine.
//
// Optional feature macro: PCTRL_PERF_EN
//   defined   -> adds oPerfStall/oPerfFlush cycle/event counters (RUN only)
//   undefined -> counters and their ports are absent
//
// Stage 0 is fetch (youngest), stage NUM_STAGES-1 is the oldest.
// Stall/flush outputs are combinational from the requests and the current
// state. oRst_n, oHalted and oState are decoded from registers only.

module pipeline_ctrl #(
    parameter int NUM_STAGES = 5,
    parameter int RST_CYCLES = 4,
    parameter int STATE_W    = 3
) (
    input  logic                  iClk,
    input  logic                  nRst,
    input  logic [NUM_STAGES-1:0] iStallReq,
    input  logic [NUM_STAGES-1:0] iFlushReq,
    input  logic [NUM_STAGES-1:0] iValid,
    input  logic                  iDbgHalt,
    input  logic                  iDbgStep,
    output logic [NUM_STAGES-1:0] oStall,
    output logic [NUM_STAGES-1:0] oFlush,
    output logic [NUM_STAGES-1:0] oRst_n,
    output logic                  oHalted,
    output logic [STATE_W-1:0]    oState
`ifdef PCTRL_PERF_EN
    ,
    output logic [31:0]           oPerfStall,
    output logic [31:0]           oPerfFlush
`endif
);

    localparam int IDX_W = $clog2(NUM_STAGES);
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [NUM_STAGES-1:0] FETCH_BIT = NUM_STAGES'(1);

    typedef enum logic [2:0] {
        S_RST_SEQ = 3'd0,
        S_RUN     = 3'd1,
        S_DRAIN   = 3'd2,
        S_HALTED  = 3'd3,
        S_STEP    = 3'd4
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             halted_q;

    logic                  stall_hit;
    logic [IDX_W-1:0]      stall_idx;
    logic                  flush_hit;
    logic [IDX_W-1:0]      flush_idx;
    logic                  flush_ok;
    logic [NUM_STAGES-1:0] norm_stall;
    logic [NUM_STAGES-1:0] norm_flush;

    // Fetch's valid bit never gates the drain: fetch is frozen while draining.
    logic unused_valid0;
    assign unused_valid0 = iValid[0];

    // Locate the oldest stalling stage and the oldest redirecting stage.
    always_comb begin
        stall_hit = 1'b0;
        stall_idx = '0;
        flush_hit = 1'b0;
        flush_idx = '0;
        for (int j = 0; j < NUM_STAGES; j++) begin
            if (iStallReq[j]) begin
                stall_hit = 1'b1;
                stall_idx = IDX_W'(j);
            end
            if (iFlushReq[j]) begin
                flush_hit = 1'b1;
                flush_idx = IDX_W'(j);
            end
        end
    end

    // A redirect is only honoured when nothing at or older than it is stalled;
    // otherwise the requester keeps asserting it until the stall clears.
    assign flush_ok = flush_hit && !(stall_hit && (stall_idx >= flush_idx));

    // Normal rules: honoured flush wipes everything younger (and overrides the
    // younger stalls together with their bubble); else the oldest stall freezes
    // itself and all younger stages and bubbles the stage just above it.
    always_comb begin
        norm_stall = '0;
        norm_flush = '0;
        for (int j = 0; j < NUM_STAGES; j++) begin
            if (flush_ok) begin
                norm_flush[j] = (j < int'(flush_idx));
            end else if (stall_hit) begin
                norm_stall[j] = (j <= int'(stall_idx));
                norm_flush[j] = (j == int'(stall_idx) + 1);
            end
        end
    end

    // Per-state output shaping. While draining, fetch is held and stage 1 is fed
    // bubbles unless an older stall already freezes stage 1.
    always_comb begin
        oStall = '0;
        oFlush = '0;
        case (state_q)
            S_RUN, S_STEP: begin
                oStall = norm_stall;
                oFlush = norm_flush;
            end
            S_DRAIN: begin
                oStall = norm_stall | FETCH_BIT;
                oFlush = norm_flush & ~FETCH_BIT;
                if (!norm_stall[1]) begin
                    oFlush[1] = 1'b1;
                end
            end
            S_HALTED: begin
                oStall = '1;
            end
            default: begin
                oStall = '0;
                oFlush = '0;
            end
        endcase
    end

    // Debug/reset sequencing FSM with registered halted flag.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state_q  <= S_RST_SEQ;
            cnt_q    <= '0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                S_RST_SEQ: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= iDbgHalt ? S_DRAIN : S_RUN;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    if (iDbgHalt) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!iDbgHalt) begin
                        state_q <= S_RUN;
                    end else if (iValid[NUM_STAGES-1:1] == '0) begin
                        state_q  <= S_HALTED;
                        halted_q <= 1'b1;
                    end
                end
                S_HALTED: begin
                    if (!iDbgHalt) begin
                        state_q  <= S_RUN;
                        halted_q <= 1'b0;
                    end else if (iDbgStep) begin
                        state_q  <= S_STEP;
                        halted_q <= 1'b0;
                    end
                end
                S_STEP: begin
                    if (!iStallReq[0]) begin
                        state_q <= S_DRAIN;
                    end
                end
                default: begin
                    state_q  <= S_RST_SEQ;
                    cnt_q    <= '0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign oRst_n  = (state_q == S_RST_SEQ) ? '0 : '1;
    assign oHalted = halted_q;
    assign oState  = STATE_W'(state_q);

`ifdef PCTRL_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    // Stall-cycle and honoured-flush counters, only advancing in RUN.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else if (state_q == S_RUN) begin
            if (|oStall) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (flush_ok) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign oPerfStall = perf_stall_q;
    assign oPerfFlush = perf_flush_q;
`endif

    // A stage that is both stalled and flushed would be held and discarded at once.
    always_ff @(posedge iClk) begin
        if (nRst) begin
            assert (!(|(oStall & oFlush)));
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus randomized RUN traffic,
// checked against a rule-level model of the stall/flush and debug behaviour.

module tb_pipeline_ctrl;

  localparam int N  = 5;
  localparam int RC = 4;
  localparam int S_RST   = 0;
  localparam int S_RUN   = 1;
  localparam int S_DRAIN = 2;
  localparam int S_HALT  = 3;
  localparam int S_STEP  = 4;

  logic         iClk = 1'b0;
  logic         nRst;
  logic [N-1:0] iStallReq, iFlushReq, iValid;
  logic         iDbgHalt, iDbgStep;
  logic [N-1:0] oStall, oFlush, oRst_n;
  logic         oHalted;
  logic [2:0]   oState;
`ifdef PCTRL_PERF_EN
  logic [31:0]  oPerfStall, oPerfFlush;
`endif

  int          vectors = 0;
  int          miscompares = 0;
  int          exp_state;
  int          exp_cnt;
  logic [31:0] exp_pstall;
  logic [31:0] exp_pflush;

  always #5 iClk = ~iClk;

  pipeline_ctrl #(.NUM_STAGES(N), .RST_CYCLES(RC), .STATE_W(3)) dut (
    .iClk(iClk), .nRst(nRst),
    .iStallReq(iStallReq), .iFlushReq(iFlushReq), .iValid(iValid),
    .iDbgHalt(iDbgHalt), .iDbgStep(iDbgStep),
    .oStall(oStall), .oFlush(oFlush), .oRst_n(oRst_n),
    .oHalted(oHalted), .oState(oState)
`ifdef PCTRL_PERF_EN
    , .oPerfStall(oPerfStall), .oPerfFlush(oPerfFlush)
`endif
  );

  // Rule model: expected stall/flush vectors for a state and request set.
  function automatic void model_out(input int st, input logic [N-1:0] sreq, freq,
                                    output logic [N-1:0] so, fo, output logic hon);
    int js, kf;
    js = -1; kf = -1; so = '0; fo = '0; hon = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (sreq[i]) js = i;
      if (freq[i]) kf = i;
    end
    if (st == S_HALT) so = '1;
    else if (st != S_RST) begin
      hon = (kf >= 0) && (js < kf);
      if (hon) begin
        for (int i = 0; i < kf; i++) fo[i] = 1'b1;
      end else if (js >= 0) begin
        for (int i = 0; i <= js; i++) so[i] = 1'b1;
        if (js + 1 < N) fo[js+1] = 1'b1;
      end
      if (st == S_DRAIN) begin
        so[0] = 1'b1;
        fo[0] = 1'b0;
        if (!so[1]) fo[1] = 1'b1;
      end
    end
  endfunction

  // Rule model: next debug state.
  function automatic int model_next(input int st, input int cnt, input logic [N-1:0] sreq, valid,
                                    input logic halt, stp, output int cnt_n);
    cnt_n = 0;
    case (st)
      S_RST:   if (cnt == RC - 1) return halt ? S_DRAIN : S_RUN;
               else begin cnt_n = cnt + 1; return S_RST; end
      S_RUN:   return halt ? S_DRAIN : S_RUN;
      S_DRAIN: if (!halt) return S_RUN;
               else return ((valid >> 1) == '0) ? S_HALT : S_DRAIN;
      S_HALT:  if (!halt) return S_RUN;
               else return stp ? S_STEP : S_HALT;
      S_STEP:  return sreq[0] ? S_STEP : S_DRAIN;
      default: return S_RST;
    endcase
  endfunction

  // Driver: apply inputs just after the falling edge.
  task automatic drive(input logic [N-1:0] s, f, v, input logic h, stp);
    @(negedge iClk);
    iStallReq = s; iFlushReq = f; iValid = v; iDbgHalt = h; iDbgStep = stp;
    #1;
  endtask

  // Advance one rising edge and move the model along with it.
  task automatic tick();
    logic [N-1:0] ms, mf;
    logic hon;
    int cn;
    @(posedge iClk);
    if (nRst) begin
      model_out(exp_state, iStallReq, iFlushReq, ms, mf, hon);
      if (exp_state == S_RUN) begin
        if (|ms) exp_pstall++;
        if (hon) exp_pflush++;
      end
      exp_state = model_next(exp_state, exp_cnt, iStallReq, iValid, iDbgHalt, iDbgStep, cn);
      exp_cnt = cn;
    end
    #1;
  endtask

  task automatic test_reset();
    nRst = 1'b1;
    iStallReq = '0; iFlushReq = '0; iValid = '0; iDbgHalt = 1'b0; iDbgStep = 1'b0;
    #1 nRst = 1'b0;
    exp_state = S_RST; exp_cnt = 0; exp_pstall = '0; exp_pflush = '0;
    iStallReq = N'($urandom); iFlushReq = N'($urandom);
    repeat (3) @(posedge iClk);
    #1;
    vectors++; if (oState !== 3'(S_RST)) begin miscompares++; $display("FAIL reset_state: got %0d expected %0d", oState, S_RST); end
    vectors++; if (oRst_n !== '0) begin miscompares++; $display("FAIL reset_rstn: got %b expected %b", oRst_n, N'(0)); end
    vectors++; if (oStall !== '0 || oFlush !== '0) begin miscompares++; $display("FAIL reset_stall_flush: got %b/%b expected 0/0", oStall, oFlush); end
    vectors++; if (oHalted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b expected 0", oHalted); end
`ifdef PCTRL_PERF_EN
    vectors++; if (oPerfStall !== 32'd0 || oPerfFlush !== 32'd0) begin miscompares++; $display("FAIL reset_perf: got %0d/%0d expected 0/0", oPerfStall, oPerfFlush); end
`endif
    @(negedge iClk);
    nRst = 1'b1;
    for (int c = 0; c < RC; c++) begin
      tick();
      vectors++;
      if (oRst_n !== ((c < RC - 1) ? N'(0) : {N{1'b1}})) begin
        miscompares++; $display("FAIL rst_seq_rstn edge %0d: got %b", c + 1, oRst_n);
      end
      vectors++; if (oState !== 3'(exp_state)) begin miscompares++; $display("FAIL rst_seq_state edge %0d: got %0d expected %0d", c + 1, oState, exp_state); end
    end
    vectors++; if (oState !== 3'(S_RUN)) begin miscompares++; $display("FAIL rst_to_run: got %0d expected %0d", oState, S_RUN); end
  endtask

  task automatic test_stall();
    drive(5'b01000, '0, '0, 1'b0, 1'b0);
    vectors++; if (oStall !== 5'b01111 || oFlush !== 5'b10000) begin miscompares++; $display("FAIL stall3: got %b/%b expected 01111/10000", oStall, oFlush); end
    tick();
    drive(5'b01010, '0, '0, 1'b0, 1'b0);
    vectors++; if (oStall !== 5'b01111 || oFlush !== 5'b10000) begin miscompares++; $display("FAIL stall3_1: got %b/%b expected 01111/10000", oStall, oFlush); end
    tick();
    drive(5'b10000, '0, '0, 1'b0, 1'b0);
    vectors++; if (oStall !== 5'b11111 || oFlush !== 5'b00000) begin miscompares++; $display("FAIL stall_oldest: got %b/%b expected 11111/00000", oStall, oFlush); end
    tick();
  endtask

  task automatic test_flush();
    drive(5'b00001, 5'b00010, '0, 1'b0, 1'b0);
    vectors++; if (oStall !== 5'b00000 || oFlush !== 5'b00001) begin miscompares++; $display("FAIL flush1_over_stall0: got %b/%b expected 00000/00001", oStall, oFlush); end
    tick();
    drive(5'b01000, 5'b00010, '0, 1'b0, 1'b0);
    vectors++; if (oStall !== 5'b01111 || oFlush !== 5'b10000) begin miscompares++; $display("FAIL flush1_blocked: got %b/%b expected 01111/10000", oStall, oFlush); end
    tick();
    drive(5'b01000, 5'b10000, '0, 1'b0, 1'b0);
    vectors++; if (oStall !== 5'b00000 || oFlush !== 5'b01111) begin miscompares++; $display("FAIL flush4_over_stall3: got %b/%b expected 00000/01111", oStall, oFlush); end
    tick();
    vectors++; if (oState !== 3'(S_RUN)) begin miscompares++; $display("FAIL flush_state: got %0d expected %0d", oState, S_RUN); end
  endtask

  task automatic test_random_run();
    logic [N-1:0] s, f, es, ef;
    logic hon;
    for (int it = 0; it < 80; it++) begin
      s = N'($urandom) & N'($urandom);
      f = '0;
      if ($urandom_range(0, 2) == 0) f[$urandom_range(0, N - 1)] = 1'b1;
      drive(s, f, N'($urandom), 1'b0, 1'($urandom_range(0, 1)));
      model_out(S_RUN, s, f, es, ef, hon);
      vectors++; if (oStall !== es || oFlush !== ef) begin miscompares++; $display("FAIL rand_run s=%b f=%b: got %b/%b expected %b/%b", s, f, oStall, oFlush, es, ef); end
      tick();
      vectors++; if (oState !== 3'(exp_state)) begin miscompares++; $display("FAIL rand_run_state: got %0d expected %0d", oState, exp_state); end
    end
`ifdef PCTRL_PERF_EN
    vectors++; if (oPerfStall !== exp_pstall || oPerfFlush !== exp_pflush) begin miscompares++; $display("FAIL perf_counts: got %0d/%0d expected %0d/%0d", oPerfStall, oPerfFlush, exp_pstall, exp_pflush); end
`endif
  endtask

  task automatic test_drain_halt();
    logic [N-1:0] v;
    int drain_cycles;
    v = 5'b11110;
    drive('0, '0, v, 1'b1, 1'b0);
    tick();
    vectors++; if (oState !== 3'(S_DRAIN)) begin miscompares++; $display("FAIL enter_drain: got %0d expected %0d", oState, S_DRAIN); end
    drain_cycles = 0;
    for (int it = 0; it < 20 && exp_state == S_DRAIN; it++) begin
      v = v << 1;
      drive('0, '0, v, 1'b1, 1'b0);
      vectors++; if (oStall !== 5'b00001 || oFlush !== 5'b00010) begin miscompares++; $display("FAIL drain_out: got %b/%b expected 00001/00010", oStall, oFlush); end
      drain_cycles++;
      tick();
      vectors++; if (oState !== 3'(exp_state)) begin miscompares++; $display("FAIL drain_state: got %0d expected %0d", oState, exp_state); end
    end
    vectors++; if (drain_cycles != 4 || exp_state != S_HALT) begin miscompares++; $display("FAIL drain_len: got %0d cycles expected 4", drain_cycles); end
    drive(N'($urandom), N'($urandom), '0, 1'b1, 1'b0);
    vectors++; if (oHalted !== 1'b1 || oState !== 3'(S_HALT)) begin miscompares++; $display("FAIL halted: got %b/%0d expected 1/%0d", oHalted, oState, S_HALT); end
    vectors++; if (oStall !== 5'b11111 || oFlush !== 5'b00000) begin miscompares++; $display("FAIL halted_out: got %b/%b expected 11111/00000", oStall, oFlush); end
    tick();
  endtask

  task automatic test_step();
    logic [N-1:0] v, es, ef;
    logic hon;
    int drain_cycles;
    drive('0, '0, '0, 1'b1, 1'b1);
    tick();
    vectors++; if (oState !== 3'(S_STEP) || oHalted !== 1'b0) begin miscompares++; $display("FAIL step_enter: got %0d/%b expected %0d/0", oState, oHalted, S_STEP); end
    v = 5'b00001;
    drive('0, '0, v, 1'b1, 1'b0);
    vectors++; if (oStall !== 5'b00000 || oFlush !== 5'b00000) begin miscompares++; $display("FAIL step_free: got %b/%b expected 00000/00000", oStall, oFlush); end
    tick();
    vectors++; if (oState !== 3'(S_DRAIN)) begin miscompares++; $display("FAIL step_to_drain: got %0d expected %0d", oState, S_DRAIN); end
    drain_cycles = 0;
    for (int it = 0; it < 20 && exp_state == S_DRAIN; it++) begin
      v = v << 1;
      drive('0, '0, v, 1'b1, 1'b0);
      drain_cycles++;
      tick();
      vectors++; if (oState !== 3'(exp_state)) begin miscompares++; $display("FAIL step_drain_state: got %0d expected %0d", oState, exp_state); end
    end
    vectors++; if (drain_cycles != 5 || oHalted !== 1'b1) begin miscompares++; $display("FAIL step_retire: got %0d cycles halted=%b expected 5/1", drain_cycles, oHalted); end
    // Step while fetch is stalled: STEP holds until fetch can move.
    drive('0, '0, '0, 1'b1, 1'b1);
    tick();
    drive(5'b00001, '0, 5'b00001, 1'b1, 1'b0);
    model_out(S_STEP, 5'b00001, '0, es, ef, hon);
    vectors++; if (oStall !== es || oFlush !== ef) begin miscompares++; $display("FAIL step_stalled_out: got %b/%b expected %b/%b", oStall, oFlush, es, ef); end
    tick();
    vectors++; if (oState !== 3'(S_STEP)) begin miscompares++; $display("FAIL step_hold: got %0d expected %0d", oState, S_STEP); end
    drive('0, '0, 5'b00001, 1'b1, 1'b0);
    tick();
    drive('0, '0, '0, 1'b1, 1'b0);
    tick();
    vectors++; if (oState !== 3'(S_HALT)) begin miscompares++; $display("FAIL step_back_halt: got %0d expected %0d", oState, S_HALT); end
    // Release wins over a simultaneous step.
    drive('0, '0, '0, 1'b0, 1'b1);
    tick();
    vectors++; if (oState !== 3'(S_RUN) || oHalted !== 1'b0) begin miscompares++; $display("FAIL release_wins: got %0d/%b expected %0d/0", oState, oHalted, S_RUN); end
  endtask

  task automatic test_reset_mid_drain();
    drive('0, '0, 5'b11110, 1'b1, 1'b0);
    tick();
    drive(5'b00100, 5'b01000, 5'b11100, 1'b1, 1'b0);
    #2 nRst = 1'b0;
    exp_state = S_RST; exp_cnt = 0; exp_pstall = '0; exp_pflush = '0;
    #1;
    vectors++; if (oState !== 3'(S_RST) || oRst_n !== '0) begin miscompares++; $display("FAIL mid_reset_state: got %0d/%b expected 0/00000", oState, oRst_n); end
    vectors++; if (oStall !== '0 || oFlush !== '0 || oHalted !== 1'b0) begin miscompares++; $display("FAIL mid_reset_out: got %b/%b/%b expected 0/0/0", oStall, oFlush, oHalted); end
`ifdef PCTRL_PERF_EN
    vectors++; if (oPerfStall !== 32'd0 || oPerfFlush !== 32'd0) begin miscompares++; $display("FAIL mid_reset_perf: got %0d/%0d expected 0/0", oPerfStall, oPerfFlush); end
`endif
    tick();
    drive('0, '0, '0, 1'b1, 1'b0);
    nRst = 1'b1;
    for (int c = 0; c < RC; c++) tick();
    vectors++; if (oState !== 3'(S_DRAIN) || oRst_n !== '1) begin miscompares++; $display("FAIL rst_into_drain: got %0d/%b expected %0d/11111", oState, oRst_n, S_DRAIN); end
    tick();
    vectors++; if (oState !== 3'(exp_state)) begin miscompares++; $display("FAIL post_rst_halt: got %0d expected %0d", oState, exp_state); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_flush();
    test_random_run();
    test_drain_halt();
    test_step();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    miscompares++;
    $display("FAIL watchdog: bench did not complete in time");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
